// File: rtl/link_mon_pkg.sv
// Shared lane state type and saturating counter helper for the multi-lane CRC link monitor.
package link_mon_pkg;

    typedef enum logic [0:0] {
        LANE_DOWN = 1'b0,
        LANE_UP   = 1'b1
    } lane_state_e;

    // Counters of any width up to SAT_W share this helper; callers pass their own ceiling.
    localparam int SAT_W = 64;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                                 input logic [SAT_W-1:0] max_val);
        logic [SAT_W-1:0] res;
        if (cnt >= max_val) begin
            res = cnt;
        end else begin
            res = cnt + 64'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/link_lane_mon.sv
// One lane of the link monitor: saturating statistics, fail-rate window and DOWN/UP hysteresis FSM.
module link_lane_mon
    import link_mon_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int FAILS_TO_DOWN = 4,
    parameter int PASSES_TO_UP  = 8,
    parameter int WIN_LOG2      = 10,
    parameter int WIN_FAIL_MAX  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic             i_crc_fail,
    input  logic             i_clear,
    output logic             o_link_up,
    output logic [CNT_W-1:0] o_total_frames,
    output logic [CNT_W-1:0] o_total_fails,
    output logic [CNT_W-1:0] o_consec_fails,
    output logic [CNT_W-1:0] o_consec_passes,
    output logic [CNT_W-1:0] o_last_win
);

    localparam logic [SAT_W-1:0]    CNT_MAX  = SAT_W'({CNT_W{1'b1}});
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    PASS_TH  = CNT_W'(PASSES_TO_UP);
    localparam logic [CNT_W-1:0]    FAIL_TH  = CNT_W'(FAILS_TO_DOWN);
    localparam logic [CNT_W-1:0]    WIN_MAX  = CNT_W'(WIN_FAIL_MAX);
    localparam logic [WIN_LOG2-1:0] WIN_LAST = {WIN_LOG2{1'b1}};

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return CNT_W'(sat_inc(SAT_W'(cnt), CNT_MAX));
    endfunction

    lane_state_e         r_state;
    lane_state_e         w_state_nx;
    logic [CNT_W-1:0]    r_total_frames, w_total_frames_nx;
    logic [CNT_W-1:0]    r_total_fails, w_total_fails_nx;
    logic [CNT_W-1:0]    r_consec_fails, w_consec_fails_nx;
    logic [CNT_W-1:0]    r_consec_passes, w_consec_passes_nx;
    logic [CNT_W-1:0]    r_last_win, w_last_win_nx;
    logic [CNT_W-1:0]    r_win_fails, w_win_fails_nx, w_win_total;
    logic [WIN_LOG2-1:0] r_win_idx, w_win_idx_nx;
    logic                w_win_close;
    logic                w_win_drop;

    // Statistics and window bookkeeping; clear wins over a coincident frame for these counters.
    always_comb begin
        w_total_frames_nx = r_total_frames;
        w_total_fails_nx  = r_total_fails;
        w_last_win_nx     = r_last_win;
        w_win_fails_nx    = r_win_fails;
        w_win_idx_nx      = r_win_idx;
        w_win_total       = r_win_fails;
        w_win_close       = 1'b0;
        if (i_clear) begin
            w_total_frames_nx = CNT_ZERO;
            w_total_fails_nx  = CNT_ZERO;
            w_last_win_nx     = CNT_ZERO;
            w_win_fails_nx    = CNT_ZERO;
            w_win_idx_nx      = {WIN_LOG2{1'b0}};
        end else if (i_valid) begin
            w_total_frames_nx = cnt_inc(r_total_frames);
            if (i_crc_fail) begin
                w_total_fails_nx = cnt_inc(r_total_fails);
                w_win_total      = cnt_inc(r_win_fails);
            end else begin
                w_total_fails_nx = r_total_fails;
                w_win_total      = r_win_fails;
            end
            if (r_win_idx == WIN_LAST) begin
                w_win_close    = 1'b1;
                w_last_win_nx  = w_win_total;
                w_win_fails_nx = CNT_ZERO;
                w_win_idx_nx   = {WIN_LOG2{1'b0}};
            end else begin
                w_win_fails_nx = w_win_total;
                w_win_idx_nx   = r_win_idx + WIN_LOG2'(1);
            end
        end else begin
            w_win_close = 1'b0;
        end
    end

    // Consecutive pass/fail run lengths follow every valid frame, cleared or not.
    always_comb begin
        w_consec_fails_nx  = r_consec_fails;
        w_consec_passes_nx = r_consec_passes;
        if (i_valid && i_crc_fail) begin
            w_consec_fails_nx  = cnt_inc(r_consec_fails);
            w_consec_passes_nx = CNT_ZERO;
        end else if (i_valid) begin
            w_consec_fails_nx  = CNT_ZERO;
            w_consec_passes_nx = cnt_inc(r_consec_passes);
        end else begin
            w_consec_fails_nx  = r_consec_fails;
            w_consec_passes_nx = r_consec_passes;
        end
    end

    // Link FSM next state; a window drop and a fail-run drop on the same frame merge into one exit.
    always_comb begin
        w_state_nx = r_state;
        w_win_drop = 1'b0;
        case (r_state)
            LANE_DOWN: begin
                if (i_valid && !i_crc_fail && (w_consec_passes_nx >= PASS_TH)) begin
                    w_state_nx = LANE_UP;
                end else begin
                    w_state_nx = LANE_DOWN;
                end
            end
            LANE_UP: begin
                if (w_win_close && (w_win_total > WIN_MAX)) begin
                    w_state_nx = LANE_DOWN;
                    w_win_drop = 1'b1;
                end else if (i_valid && i_crc_fail && (w_consec_fails_nx >= FAIL_TH)) begin
                    w_state_nx = LANE_DOWN;
                end else begin
                    w_state_nx = LANE_UP;
                end
            end
            default: begin
                w_state_nx = LANE_DOWN;
            end
        endcase
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= LANE_DOWN;
            r_total_frames  <= CNT_ZERO;
            r_total_fails   <= CNT_ZERO;
            r_consec_fails  <= CNT_ZERO;
            r_consec_passes <= CNT_ZERO;
            r_last_win      <= CNT_ZERO;
            r_win_fails     <= CNT_ZERO;
            r_win_idx       <= {WIN_LOG2{1'b0}};
        end else begin
            r_state         <= w_state_nx;
            r_total_frames  <= w_total_frames_nx;
            r_total_fails   <= w_total_fails_nx;
            r_consec_fails  <= w_consec_fails_nx;
            r_consec_passes <= w_win_drop ? CNT_ZERO : w_consec_passes_nx;
            r_last_win      <= w_last_win_nx;
            r_win_fails     <= w_win_fails_nx;
            r_win_idx       <= w_win_idx_nx;
        end
    end

    assign o_link_up       = (r_state == LANE_UP);
    assign o_total_frames  = r_total_frames;
    assign o_total_fails   = r_total_fails;
    assign o_consec_fails  = r_consec_fails;
    assign o_consec_passes = r_consec_passes;
    assign o_last_win      = r_last_win;

endmodule

// File: rtl/link_monitor_mc.sv
// Multi-lane CRC link monitor: per-lane monitors, link change detect, all-up flag and registered readback.
module link_monitor_mc
    import link_mon_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int CNT_W         = 32,
    parameter int FAILS_TO_DOWN = 4,
    parameter int PASSES_TO_UP  = 8,
    parameter int WIN_LOG2      = 10,
    parameter int WIN_FAIL_MAX  = 8,
    localparam int SEL_W        = $clog2(NUM_LANES) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] valid,
    input  logic [NUM_LANES-1:0] crc_fail,
    input  logic                 clear,
    input  logic [SEL_W-1:0]     rd_lane,
    output logic [NUM_LANES-1:0] link_up,
    output logic [NUM_LANES-1:0] link_chg,
    output logic                 all_up,
    output logic [CNT_W-1:0]     rd_total_frames,
    output logic [CNT_W-1:0]     rd_total_fails,
    output logic [CNT_W-1:0]     rd_consec_fails,
    output logic [CNT_W-1:0]     rd_consec_passes,
    output logic [CNT_W-1:0]     rd_last_win
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [NUM_LANES-1:0] w_link_up;
    logic [NUM_LANES-1:0] r_link_prev;
    logic [CNT_W-1:0]     w_total_frames  [NUM_LANES];
    logic [CNT_W-1:0]     w_total_fails   [NUM_LANES];
    logic [CNT_W-1:0]     w_consec_fails  [NUM_LANES];
    logic [CNT_W-1:0]     w_consec_passes [NUM_LANES];
    logic [CNT_W-1:0]     w_last_win      [NUM_LANES];
    logic [CNT_W-1:0]     w_sel_tf, w_sel_tfl, w_sel_cf, w_sel_cp, w_sel_lw;
    logic [CNT_W-1:0]     r_rd_tf, r_rd_tfl, r_rd_cf, r_rd_cp, r_rd_lw;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        link_lane_mon #(
            .CNT_W         (CNT_W),
            .FAILS_TO_DOWN (FAILS_TO_DOWN),
            .PASSES_TO_UP  (PASSES_TO_UP),
            .WIN_LOG2      (WIN_LOG2),
            .WIN_FAIL_MAX  (WIN_FAIL_MAX)
        ) u_lane (
            .clk             (clk),
            .rst_n           (rst_n),
            .i_valid         (valid[g]),
            .i_crc_fail      (crc_fail[g]),
            .i_clear         (clear),
            .o_link_up       (w_link_up[g]),
            .o_total_frames  (w_total_frames[g]),
            .o_total_fails   (w_total_fails[g]),
            .o_consec_fails  (w_consec_fails[g]),
            .o_consec_passes (w_consec_passes[g]),
            .o_last_win      (w_last_win[g])
        );
    end

    // Lane select as an AND-OR mux; an out-of-range selection matches no lane and yields zero.
    always_comb begin
        w_sel_tf  = CNT_ZERO;
        w_sel_tfl = CNT_ZERO;
        w_sel_cf  = CNT_ZERO;
        w_sel_cp  = CNT_ZERO;
        w_sel_lw  = CNT_ZERO;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_sel_tf  = w_sel_tf  | (w_total_frames[i]  & {CNT_W{rd_lane == SEL_W'(i)}});
            w_sel_tfl = w_sel_tfl | (w_total_fails[i]   & {CNT_W{rd_lane == SEL_W'(i)}});
            w_sel_cf  = w_sel_cf  | (w_consec_fails[i]  & {CNT_W{rd_lane == SEL_W'(i)}});
            w_sel_cp  = w_sel_cp  | (w_consec_passes[i] & {CNT_W{rd_lane == SEL_W'(i)}});
            w_sel_lw  = w_sel_lw  | (w_last_win[i]      & {CNT_W{rd_lane == SEL_W'(i)}});
        end
    end

    // Readback registers and previous link state for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link_prev <= {NUM_LANES{1'b0}};
            r_rd_tf     <= CNT_ZERO;
            r_rd_tfl    <= CNT_ZERO;
            r_rd_cf     <= CNT_ZERO;
            r_rd_cp     <= CNT_ZERO;
            r_rd_lw     <= CNT_ZERO;
        end else begin
            r_link_prev <= w_link_up;
            r_rd_tf     <= w_sel_tf;
            r_rd_tfl    <= w_sel_tfl;
            r_rd_cf     <= w_sel_cf;
            r_rd_cp     <= w_sel_cp;
            r_rd_lw     <= w_sel_lw;
        end
    end

    assign link_up          = w_link_up;
    assign link_chg         = w_link_up ^ r_link_prev;
    assign all_up           = &w_link_up;
    assign rd_total_frames  = r_rd_tf;
    assign rd_total_fails   = r_rd_tfl;
    assign rd_consec_fails  = r_rd_cf;
    assign rd_consec_passes = r_rd_cp;
    assign rd_last_win      = r_rd_lw;

endmodule

// File: tb/tb_link_monitor_mc.sv
// Self-checking bench for link_monitor_mc: directed scenarios plus randomized traffic against a counting model.
module tb_link_monitor_mc;

    localparam int NL = 4, CW = 32, WL = 4, WMAX = 2, FTD = 4, PTU = 8;
    localparam int SW = $clog2(NL) + 1;
    localparam int WIN_LEN = 1 << WL;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NL-1:0] valid = '0, crc_fail = '0;
    logic clear = 1'b0;
    logic [SW-1:0] rd_lane = '0;
    logic [NL-1:0] link_up, link_chg;
    logic all_up;
    logic [CW-1:0] rd_total_frames, rd_total_fails, rd_consec_fails, rd_consec_passes, rd_last_win;

    logic [NL-1:0] s_valid = '0, s_crc_fail = '0;
    logic [SW-1:0] s_rd_lane = '0;
    logic [NL-1:0] s_link_up, s_link_chg;
    logic s_all_up;
    logic [3:0] s_rd_tf, s_rd_tfl, s_rd_cf, s_rd_cp, s_rd_lw;

    link_monitor_mc #(.NUM_LANES(NL), .CNT_W(CW), .WIN_LOG2(WL), .WIN_FAIL_MAX(WMAX)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .crc_fail(crc_fail), .clear(clear), .rd_lane(rd_lane),
        .link_up(link_up), .link_chg(link_chg), .all_up(all_up),
        .rd_total_frames(rd_total_frames), .rd_total_fails(rd_total_fails),
        .rd_consec_fails(rd_consec_fails), .rd_consec_passes(rd_consec_passes), .rd_last_win(rd_last_win));

    // Narrow-counter instance so saturation is reachable by real traffic.
    link_monitor_mc #(.NUM_LANES(NL), .CNT_W(4), .WIN_LOG2(WL), .WIN_FAIL_MAX(WMAX)) dut_s (
        .clk(clk), .rst_n(rst_n), .valid(s_valid), .crc_fail(s_crc_fail), .clear(1'b0), .rd_lane(s_rd_lane),
        .link_up(s_link_up), .link_chg(s_link_chg), .all_up(s_all_up),
        .rd_total_frames(s_rd_tf), .rd_total_fails(s_rd_tfl),
        .rd_consec_fails(s_rd_cf), .rd_consec_passes(s_rd_cp), .rd_last_win(s_rd_lw));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint m_tf[NL], m_tfl[NL], m_cf[NL], m_cp[NL], m_wcnt[NL], m_wf[NL], m_lw[NL];
    bit     m_up[NL], m_chg[NL];
    logic [NL-1:0] e_up, e_chg;
    logic [CW-1:0] e_tf, e_tfl, e_cf, e_cp, e_lw;

    function automatic longint msat(longint x);
        return (x >= MAXV) ? x : x + 64'sd1;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            m_tf[l] = 0; m_tfl[l] = 0; m_cf[l] = 0; m_cp[l] = 0;
            m_wcnt[l] = 0; m_wf[l] = 0; m_lw[l] = 0; m_up[l] = 0; m_chg[l] = 0;
        end
        e_up = '0; e_chg = '0;
    endtask

    task automatic model_step();
        bit prev, drop, v, f;
        for (int l = 0; l < NL; l++) begin
            v = valid[l]; f = crc_fail[l]; prev = m_up[l]; drop = 1'b0;
            if (v && f) begin m_cf[l] = msat(m_cf[l]); m_cp[l] = 0; end
            if (v && !f) begin m_cp[l] = msat(m_cp[l]); m_cf[l] = 0; end
            if (clear) begin
                m_tf[l] = 0; m_tfl[l] = 0; m_wcnt[l] = 0; m_wf[l] = 0; m_lw[l] = 0;
            end else if (v) begin
                m_tf[l] = msat(m_tf[l]);
                if (f) begin m_tfl[l] = msat(m_tfl[l]); m_wf[l] = msat(m_wf[l]); end
                m_wcnt[l] = m_wcnt[l] + 1;
                if (m_wcnt[l] == WIN_LEN) begin
                    m_lw[l] = m_wf[l]; m_wcnt[l] = 0; m_wf[l] = 0;
                    drop = (m_lw[l] > WMAX);
                end
            end
            if (m_up[l]) begin
                if (drop) begin m_up[l] = 0; m_cp[l] = 0; end
                else if (v && f && m_cf[l] >= FTD) m_up[l] = 0;
            end else if (v && !f && m_cp[l] >= PTU) begin
                m_up[l] = 1;
            end
            m_chg[l] = (m_up[l] != prev);
            e_up[l] = m_up[l]; e_chg[l] = m_chg[l];
        end
    endtask

    // Expected readback is taken from the model before the edge that registers it.
    task automatic tick();
        int idx;
        idx = int'(rd_lane);
        if (idx < NL) begin
            e_tf = CW'(m_tf[idx]); e_tfl = CW'(m_tfl[idx]); e_cf = CW'(m_cf[idx]);
            e_cp = CW'(m_cp[idx]); e_lw = CW'(m_lw[idx]);
        end else begin
            e_tf = '0; e_tfl = '0; e_cf = '0; e_cp = '0; e_lw = '0;
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NL-1:0] v, input logic [NL-1:0] f, input logic c);
        valid = v; crc_fail = f; clear = c;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        checks++;
        if ({link_up, link_chg, all_up} !== '0 || {rd_total_frames, rd_total_fails, rd_consec_fails,
             rd_consec_passes, rd_last_win} !== '0) begin
            errors++; $display("FAIL reset_outputs got up=%h chg=%h all=%b tf=%0d", link_up, link_chg, all_up, rd_total_frames);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (link_up !== 4'h0 || rd_total_frames !== 32'd0) begin
            errors++; $display("FAIL reset_release got up=%h tf=%0d want 0 0", link_up, rd_total_frames);
        end
    endtask

    task automatic test_train();
        rd_lane = 3'd0;
        for (int k = 0; k < 8; k++) begin
            drive(4'b0001, 4'b0000, 1'b0);
            tick();
            checks++;
            if (link_up !== e_up || link_up !== ((k == 7) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL train_up frame %0d got %h want %h", k, link_up, e_up);
            end
        end
        checks++;
        if (link_chg !== 4'b0001) begin errors++; $display("FAIL train_chg got %h want 1", link_chg); end
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        checks++;
        if (link_chg !== 4'b0000 || link_up !== 4'b0001 || rd_consec_passes !== 32'd8 || rd_consec_passes !== e_cp) begin
            errors++; $display("FAIL train_after got chg=%h up=%h cp=%0d want 0 1 8", link_chg, link_up, rd_consec_passes);
        end
    endtask

    task automatic test_fail_drop();
        for (int k = 0; k < 3; k++) begin drive(4'b0001, 4'b0001, 1'b0); tick(); end
        drive(4'b0001, 4'b0000, 1'b0); tick();
        drive(4'b0000, 4'b0000, 1'b0); tick();
        checks++;
        if (link_up[0] !== 1'b1 || rd_consec_fails !== 32'd0 || rd_consec_passes !== 32'd1) begin
            errors++; $display("FAIL fail3_hold got up=%b cf=%0d cp=%0d want 1 0 1", link_up[0], rd_consec_fails, rd_consec_passes);
        end
        for (int k = 0; k < 4; k++) begin
            drive(4'b0001, 4'b0001, 1'b0); tick();
            checks++;
            if (link_up[0] !== ((k == 3) ? 1'b0 : 1'b1) || link_chg !== e_chg) begin
                errors++; $display("FAIL fail4_drop frame %0d got up=%b chg=%h want %b %h", k, link_up[0], link_chg, e_up[0], e_chg);
            end
        end
        drive(4'b0000, 4'b0000, 1'b0); tick();
        checks++;
        if (rd_total_fails !== 32'd7 || rd_total_frames !== 32'd16 || rd_last_win !== 32'd7 || link_chg !== 4'h0) begin
            errors++; $display("FAIL fail4_stats got tfl=%0d tf=%0d lw=%0d chg=%h want 7 16 7 0",
                               rd_total_fails, rd_total_frames, rd_last_win, link_chg);
        end
    endtask

    task automatic test_window_drop();
        rd_lane = 3'd1;
        for (int k = 0; k < 8; k++) begin drive(4'b0010, 4'b0000, 1'b0); tick(); end
        drive(4'b0000, 4'b0000, 1'b1); tick();
        for (int k = 0; k < 16; k++) begin
            drive(4'b0010, (k % 4 == 3) ? 4'b0010 : 4'b0000, 1'b0); tick();
            checks++;
            if (link_up[1] !== ((k == 15) ? 1'b0 : 1'b1) || link_chg !== e_chg) begin
                errors++; $display("FAIL win_drop frame %0d got up=%b chg=%h want %b %h", k, link_up[1], link_chg, e_up[1], e_chg);
            end
        end
        drive(4'b0000, 4'b0000, 1'b0); tick();
        checks++;
        if (rd_last_win !== 32'd4 || rd_consec_passes !== 32'd0 || rd_consec_fails !== 32'd1) begin
            errors++; $display("FAIL win_stats got lw=%0d cp=%0d cf=%0d want 4 0 1", rd_last_win, rd_consec_passes, rd_consec_fails);
        end
        for (int k = 0; k < 8; k++) begin
            drive(4'b0010, 4'b0000, 1'b0); tick();
            checks++;
            if (link_up[1] !== ((k == 7) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL win_recover pass %0d got up=%b want %b", k, link_up[1], e_up[1]);
            end
        end
    endtask

    task automatic test_all_lanes();
        for (int k = 0; k < 4; k++) begin drive(4'b0010, 4'b0010, 1'b0); tick(); end
        for (int k = 0; k < 8; k++) begin drive(4'hF, 4'h0, 1'b0); tick(); end
        checks++;
        if (link_up !== 4'hF || link_chg !== 4'hF || all_up !== 1'b1) begin
            errors++; $display("FAIL all_train got up=%h chg=%h all=%b want f f 1", link_up, link_chg, all_up);
        end
        for (int k = 0; k < 4; k++) begin drive(4'b1000, 4'b1000, 1'b0); tick(); end
        checks++;
        if (link_up !== 4'b0111 || link_chg !== 4'b1000 || all_up !== 1'b0) begin
            errors++; $display("FAIL all_drop got up=%h chg=%h all=%b want 7 8 0", link_up, link_chg, all_up);
        end
    endtask

    task automatic test_saturation();
        logic [CW-1:0] cp_before;
        drive(4'h0, 4'h0, 1'b0);
        s_rd_lane = 3'd2;
        for (int k = 0; k < 14; k++) begin s_valid = 4'b0100; tick(); end
        s_valid = 4'b0000; tick();
        checks++;
        if (s_rd_tf !== 4'hE) begin errors++; $display("FAIL sat_pre got tf=%0d want 14", s_rd_tf); end
        for (int k = 0; k < 3; k++) begin s_valid = 4'b0100; tick(); end
        s_valid = 4'b0000; tick();
        checks++;
        if (s_rd_tf !== 4'hF || s_rd_cp !== 4'hF || s_link_up !== 4'b0100) begin
            errors++; $display("FAIL sat_max got tf=%0d cp=%0d up=%h want 15 15 4", s_rd_tf, s_rd_cp, s_link_up);
        end
        rd_lane = 3'd2;
        cp_before = CW'(m_cp[2]);
        drive(4'b0100, 4'b0000, 1'b1); tick();
        drive(4'b0000, 4'b0000, 1'b0); tick();
        checks++;
        if (rd_total_frames !== 32'd0 || rd_consec_passes !== cp_before + 32'd1 || rd_consec_passes !== e_cp ||
            link_up[2] !== 1'b1) begin
            errors++; $display("FAIL clear_valid got tf=%0d cp=%0d up=%b want 0 %0d 1",
                               rd_total_frames, rd_consec_passes, link_up[2], cp_before + 32'd1);
        end
    endtask

    task automatic test_random();
        int pct;
        for (int c = 0; c < 800; c++) begin
            case ((c / 100) % 4)
                0: pct = 3;
                1: pct = 45;
                2: pct = 0;
                default: pct = 20;
            endcase
            for (int l = 0; l < NL; l++) begin
                valid[l] = ($urandom_range(0, 99) < 80);
                crc_fail[l] = ($urandom_range(0, 99) < pct);
            end
            clear = ($urandom_range(0, 59) == 0);
            rd_lane = SW'($urandom_range(0, 7));
            tick();
            checks++;
            if (link_up !== e_up || link_chg !== e_chg || all_up !== (&e_up)) begin
                errors++; $display("FAIL rnd_link cyc %0d got up=%h chg=%h all=%b want %h %h %b",
                                   c, link_up, link_chg, all_up, e_up, e_chg, &e_up);
            end
            checks++;
            if (rd_total_frames !== e_tf || rd_total_fails !== e_tfl || rd_consec_fails !== e_cf ||
                rd_consec_passes !== e_cp || rd_last_win !== e_lw) begin
                errors++; $display("FAIL rnd_rd cyc %0d got %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d", c,
                                   rd_total_frames, rd_total_fails, rd_consec_fails, rd_consec_passes, rd_last_win,
                                   e_tf, e_tfl, e_cf, e_cp, e_lw);
            end
        end
    endtask

    task automatic test_readback();
        logic [CW-1:0] h_tf;
        drive(4'b0100, 4'b0100, 1'b0); tick();
        drive(4'b0100, 4'b0000, 1'b0); tick();
        drive(4'h0, 4'h0, 1'b0);
        rd_lane = 3'd2; tick();
        h_tf = e_tf;
        checks++;
        if (rd_total_frames !== e_tf || rd_total_fails !== e_tfl || rd_consec_passes !== e_cp || rd_last_win !== e_lw) begin
            errors++; $display("FAIL rd_lane2 got tf=%0d tfl=%0d cp=%0d want %0d %0d %0d",
                               rd_total_frames, rd_total_fails, rd_consec_passes, e_tf, e_tfl, e_cp);
        end
        rd_lane = 3'd7;
        #1;
        checks++;
        if (rd_total_frames !== h_tf) begin errors++; $display("FAIL rd_latency got %0d want %0d", rd_total_frames, h_tf); end
        tick();
        checks++;
        if ({rd_total_frames, rd_total_fails, rd_consec_fails, rd_consec_passes, rd_last_win} !== '0) begin
            errors++; $display("FAIL rd_lane7 got tf=%0d cp=%0d want 0", rd_total_frames, rd_consec_passes);
        end
        rd_lane = 3'd4; tick();
        checks++;
        if ({rd_total_frames, rd_total_fails, rd_consec_fails, rd_consec_passes, rd_last_win} !== '0) begin
            errors++; $display("FAIL rd_lane4 got tf=%0d cp=%0d want 0", rd_total_frames, rd_consec_passes);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin drive(4'hF, 4'b0001, 1'b0); rd_lane = 3'd0; tick(); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({link_up, link_chg, all_up} !== '0 || {rd_total_frames, rd_total_fails, rd_consec_fails,
             rd_consec_passes, rd_last_win} !== '0) begin
            errors++; $display("FAIL mid_reset got up=%h chg=%h tf=%0d cf=%0d want 0", link_up, link_chg, rd_total_frames, rd_consec_fails);
        end
        model_reset();
        drive(4'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(4'b0001, (k == 0 || k == 5 || k == 10) ? 4'b0001 : 4'b0000, 1'b0); tick();
        end
        drive(4'h0, 4'h0, 1'b0); tick();
        checks++;
        if (rd_last_win !== 32'd3 || rd_total_frames !== 32'd16 || rd_last_win !== e_lw) begin
            errors++; $display("FAIL mid_reset_win got lw=%0d tf=%0d want 3 16", rd_last_win, rd_total_frames);
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_fail_drop();
        test_window_drop();
        test_all_lanes();
        test_saturation();
        test_random();
        test_readback();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
